// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: operand/register typedefs plus the forwarding
// select and hazard FSM encodings used by the forwarding/hazard unit.
package cpu_types_pkg;

    localparam int XLEN      = 32;
    localparam int NREG_BITS = 5;

    typedef logic [NREG_BITS-1:0] regbits_t;
    typedef logic [XLEN-1:0]      word_t;

    // Operand source per read port, newest producer wins
    typedef enum logic [1:0] {
        FWD_RF   = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2,
        FWD_HIST = 2'd3
    } fwd_sel_t;

    // Informative hazard state, never gates stall by itself
    typedef enum logic [1:0] {
        HZ_IDLE      = 2'd0,
        HZ_LU_BUBBLE = 2'd1,
        HZ_MEM_WAIT  = 2'd2
    } hz_state_t;

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// Pipeline-side bundle of the forwarding/hazard unit: stage tags in,
// forwarded operands, stall and stall counter out.
interface forwarding_hazard_unit_if
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int NRD    = 2,
    parameter int CNT_W  = 32
);
    logic                    flush;
    logic [NRD*REG_AW-1:0]   rs_addr;
    logic [NRD-1:0]          rs_used;
    logic                    ex_wen;
    logic                    ex_is_load;
    logic [REG_AW-1:0]       ex_waddr;
    logic                    mem_wen;
    logic                    mem_is_load;
    logic [REG_AW-1:0]       mem_waddr;
    logic [DATA_W-1:0]       mem_wdata;
    logic                    mem_ready;
    logic                    wb_wen;
    logic [REG_AW-1:0]       wb_waddr;
    logic [DATA_W-1:0]       wb_wdata;
    logic [2*NRD-1:0]        fwd_sel;
    logic [NRD*DATA_W-1:0]   fwd_data;
    logic                    stall;
    logic [CNT_W-1:0]        stall_cycles;
    hz_state_t               hz_state;

    modport master (
        output flush, rs_addr, rs_used,
        output ex_wen, ex_is_load, ex_waddr,
        output mem_wen, mem_is_load, mem_waddr, mem_wdata, mem_ready,
        output wb_wen, wb_waddr, wb_wdata,
        input  fwd_sel, fwd_data, stall, stall_cycles, hz_state
    );

    modport slave (
        input  flush, rs_addr, rs_used,
        input  ex_wen, ex_is_load, ex_waddr,
        input  mem_wen, mem_is_load, mem_waddr, mem_wdata, mem_ready,
        input  wb_wen, wb_waddr, wb_wdata,
        output fwd_sel, fwd_data, stall, stall_cycles, hz_state
    );

endinterface

// File: rtl/fwd_port_mux.sv
// One operand read port: picks the newest in-flight producer of rs_addr
// and flags load-use and MEM-wait hazards for that port.
module fwd_port_mux
    import cpu_types_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int HIST_DEPTH = 1
) (
    input  logic [REG_AW-1:0]                  i_rs_addr,
    input  logic                               i_rs_used,
    input  logic                               i_ex_wen,
    input  logic                               i_ex_is_load,
    input  logic [REG_AW-1:0]                  i_ex_waddr,
    input  logic                               i_mem_wen,
    input  logic                               i_mem_is_load,
    input  logic                               i_mem_ready,
    input  logic [REG_AW-1:0]                  i_mem_waddr,
    input  logic [DATA_W-1:0]                  i_mem_wdata,
    input  logic                               i_wb_wen,
    input  logic [REG_AW-1:0]                  i_wb_waddr,
    input  logic [DATA_W-1:0]                  i_wb_wdata,
    input  logic [HIST_DEPTH-1:0]              i_hist_vld,
    input  logic [HIST_DEPTH-1:0][REG_AW-1:0]  i_hist_addr,
    input  logic [HIST_DEPTH-1:0][DATA_W-1:0]  i_hist_data,
    output fwd_sel_t                           o_sel,
    output logic [DATA_W-1:0]                  o_data,
    output logic                               o_lu_haz,
    output logic                               o_mw_haz
);
    logic w_rd_ok;
    logic w_mem_hit;
    logic w_wb_hit;

    // r0 is hardwired zero, so it never matches a producer
    assign w_rd_ok   = i_rs_used && (i_rs_addr != '0);
    assign w_mem_hit = w_rd_ok && i_mem_wen && (i_mem_waddr == i_rs_addr);
    assign w_wb_hit  = w_rd_ok && i_wb_wen  && (i_wb_waddr  == i_rs_addr);
    assign o_mw_haz  = w_mem_hit && i_mem_is_load && !i_mem_ready;
    assign o_lu_haz  = w_rd_ok && i_ex_wen && i_ex_is_load && (i_ex_waddr == i_rs_addr);

    // Newest producer wins; a MEM load without data blocks older sources
    // because they would hand out a stale value
    always_comb begin
        o_sel  = FWD_RF;
        o_data = '0;
        if (w_mem_hit) begin
            if (!o_mw_haz) begin
                o_sel  = FWD_MEM;
                o_data = i_mem_wdata;
            end
        end else if (w_wb_hit) begin
            o_sel  = FWD_WB;
            o_data = i_wb_wdata;
        end else begin
            // Walk oldest to newest so entry 0 (newest) has the last word
            for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
                if (w_rd_ok && i_hist_vld[k] && (i_hist_addr[k] == i_rs_addr)) begin
                    o_sel  = FWD_HIST;
                    o_data = i_hist_data[k];
                end
            end
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Forwarding and hazard unit: per-port operand muxes, post-WB history,
// informative hazard FSM and saturating stall-cycle counter.
module forwarding_hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int NRD        = 2,
    parameter int HIST_DEPTH = 1,
    parameter int CNT_W      = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    forwarding_hazard_unit_if.slave  bus
);
    logic [HIST_DEPTH-1:0]             r_hist_vld;
    logic [HIST_DEPTH-1:0][REG_AW-1:0] r_hist_addr;
    logic [HIST_DEPTH-1:0][DATA_W-1:0] r_hist_data;
    hz_state_t                         r_state;
    hz_state_t                         w_state_nxt;
    logic [CNT_W-1:0]                  r_stall_cnt;

    fwd_sel_t                          w_sel [NRD];
    logic [NRD-1:0][DATA_W-1:0]        w_data;
    logic [NRD-1:0]                    w_lu_haz;
    logic [NRD-1:0]                    w_mw_haz;
    logic [2*NRD-1:0]                  w_sel_flat;
    logic                              w_lu;
    logic                              w_mw;
    logic                              w_stall;
    logic                              w_push_vld;

    for (genvar gi = 0; gi < NRD; gi++) begin : g_port
        fwd_port_mux #(
            .DATA_W     (DATA_W),
            .REG_AW     (REG_AW),
            .HIST_DEPTH (HIST_DEPTH)
        ) u_mux (
            .i_rs_addr     (bus.rs_addr[gi*REG_AW +: REG_AW]),
            .i_rs_used     (bus.rs_used[gi]),
            .i_ex_wen      (bus.ex_wen),
            .i_ex_is_load  (bus.ex_is_load),
            .i_ex_waddr    (bus.ex_waddr),
            .i_mem_wen     (bus.mem_wen),
            .i_mem_is_load (bus.mem_is_load),
            .i_mem_ready   (bus.mem_ready),
            .i_mem_waddr   (bus.mem_waddr),
            .i_mem_wdata   (bus.mem_wdata),
            .i_wb_wen      (bus.wb_wen),
            .i_wb_waddr    (bus.wb_waddr),
            .i_wb_wdata    (bus.wb_wdata),
            .i_hist_vld    (r_hist_vld),
            .i_hist_addr   (r_hist_addr),
            .i_hist_data   (r_hist_data),
            .o_sel         (w_sel[gi]),
            .o_data        (w_data[gi]),
            .o_lu_haz      (w_lu_haz[gi]),
            .o_mw_haz      (w_mw_haz[gi])
        );
    end

    assign w_lu       = |w_lu_haz;
    assign w_mw       = |w_mw_haz;
    assign w_stall    = !RST && !bus.flush && (w_lu || w_mw);
    assign w_push_vld = bus.wb_wen && (bus.wb_waddr != '0);

    // Flatten per-port selects onto the output bus
    always_comb begin
        w_sel_flat = '0;
        for (int i = 0; i < NRD; i++) begin
            w_sel_flat[2*i +: 2] = w_sel[i];
        end
    end

    assign bus.fwd_sel      = RST ? '0 : w_sel_flat;
    assign bus.fwd_data     = RST ? '0 : w_data;
    assign bus.stall        = w_stall;
    assign bus.stall_cycles = r_stall_cnt;
    assign bus.hz_state     = r_state;

    // History shifts every cycle, stall or not, so a WB write stays
    // visible for exactly HIST_DEPTH cycles after it leaves WB
    always_ff @(posedge CLK) begin
        for (int k = HIST_DEPTH - 1; k >= 1; k--) begin
            r_hist_addr[k] <= r_hist_addr[k-1];
            r_hist_data[k] <= r_hist_data[k-1];
        end
        r_hist_addr[0] <= bus.wb_waddr;
        r_hist_data[0] <= bus.wb_wdata;
        if (RST || bus.flush) begin
            r_hist_vld <= '0;
        end else begin
            for (int k = HIST_DEPTH - 1; k >= 1; k--) begin
                r_hist_vld[k] <= r_hist_vld[k-1];
            end
            r_hist_vld[0] <= w_push_vld;
        end
    end

    // Hazard state register
    always_ff @(posedge CLK) begin
        if (RST || bus.flush) begin
            r_state <= HZ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Hazard next-state: tracks why the pipe is stalled, for debug
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HZ_IDLE: begin
                if (w_lu)      w_state_nxt = HZ_LU_BUBBLE;
                else if (w_mw) w_state_nxt = HZ_MEM_WAIT;
            end
            HZ_LU_BUBBLE: begin
                w_state_nxt = w_mw ? HZ_MEM_WAIT : HZ_IDLE;
            end
            HZ_MEM_WAIT: begin
                if (bus.mem_ready) w_state_nxt = HZ_IDLE;
            end
            default: w_state_nxt = HZ_IDLE;
        endcase
    end

    // Saturating count of stalled cycles
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Scoreboard bench for forwarding_hazard_unit: directed scenarios then
// random traffic, expected values from a queue-based reference model.
module tb_forwarding_hazard_unit;
    import cpu_types_pkg::*;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int NRD    = 2;
    localparam int HD     = 2;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    typedef struct {
        logic                   rst, flush;
        logic [1:0][4:0]        rs;
        logic [1:0]             used;
        logic                   ex_wen, ex_ld;
        logic [4:0]             ex_wa;
        logic                   mem_wen, mem_ld, mem_rdy;
        logic [4:0]             mem_wa;
        logic [31:0]            mem_wd;
        logic                   wb_wen;
        logic [4:0]             wb_wa;
        logic [31:0]            wb_wd;
    } stim_t;

    typedef struct {
        logic [1:0][1:0]  sel;
        logic [1:0][31:0] data;
        logic             stall;
        logic [3:0]       cnt;
        logic [1:0]       st;
    } exp_t;

    typedef struct {
        bit         v;
        bit [4:0]   a;
        bit [31:0]  d;
    } hent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    forwarding_hazard_unit_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NRD(NRD), .CNT_W(CNT_W)) bus ();

    forwarding_hazard_unit #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .NRD(NRD), .HIST_DEPTH(HD), .CNT_W(CNT_W)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    exp_t  q[$];
    hent_t hist[$];
    int    m_cnt;
    int    m_st;
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic stim_t idle_s();
        stim_t s;
        s.rst = 0; s.flush = 0; s.rs = '0; s.used = '0;
        s.ex_wen = 0; s.ex_ld = 0; s.ex_wa = '0;
        s.mem_wen = 0; s.mem_ld = 0; s.mem_rdy = 1; s.mem_wa = '0; s.mem_wd = '0;
        s.wb_wen = 0; s.wb_wa = '0; s.wb_wd = '0;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        rst             = s.rst;
        bus.flush       = s.flush;
        bus.rs_addr     = s.rs;
        bus.rs_used     = s.used;
        bus.ex_wen      = s.ex_wen;
        bus.ex_is_load  = s.ex_ld;
        bus.ex_waddr    = s.ex_wa;
        bus.mem_wen     = s.mem_wen;
        bus.mem_is_load = s.mem_ld;
        bus.mem_ready   = s.mem_rdy;
        bus.mem_waddr   = s.mem_wa;
        bus.mem_wdata   = s.mem_wd;
        bus.wb_wen      = s.wb_wen;
        bus.wb_waddr    = s.wb_wa;
        bus.wb_wdata    = s.wb_wd;
    endtask

    function automatic void clear_hist();
        hent_t h;
        h.v = 0; h.a = '0; h.d = '0;
        hist.delete();
        for (int k = 0; k < HD; k++) hist.push_back(h);
    endfunction

    // Issue one cycle: drive, predict from the rules, push, then advance model
    task automatic apply(input stim_t s);
        exp_t  e;
        bit    any_lu, any_mw, found;
        hent_t h;
        @(posedge clk);
        #1;
        drive(s);
        any_lu = 0; any_mw = 0;
        for (int p = 0; p < NRD; p++) begin
            bit [4:0] a;
            bit       ok;
            a = s.rs[p];
            ok = s.used[p] && (a != 0);
            e.sel[p] = 2'd0; e.data[p] = '0;
            if (ok && s.ex_wen && s.ex_ld && s.ex_wa == a) any_lu = 1;
            if (ok && s.mem_wen && s.mem_wa == a) begin
                if (s.mem_ld && !s.mem_rdy) any_mw = 1;
                else begin e.sel[p] = 2'd1; e.data[p] = s.mem_wd; end
            end else if (ok && s.wb_wen && s.wb_wa == a) begin
                e.sel[p] = 2'd2; e.data[p] = s.wb_wd;
            end else if (ok) begin
                found = 0;
                foreach (hist[k]) begin
                    if (!found && hist[k].v && hist[k].a == a) begin
                        found = 1; e.sel[p] = 2'd3; e.data[p] = hist[k].d;
                    end
                end
            end
            if (s.rst) begin e.sel[p] = 2'd0; e.data[p] = '0; end
        end
        e.stall = !s.rst && !s.flush && (any_lu || any_mw);
        e.cnt   = 4'(m_cnt);
        e.st    = 2'(m_st);
        q.push_back(e);
        // model update at the coming edge
        if (s.rst) m_cnt = 0;
        else if (e.stall && m_cnt < CMAX) m_cnt++;
        if (s.rst || s.flush) m_st = 0;
        else if (m_st == 0) m_st = any_lu ? 1 : (any_mw ? 2 : 0);
        else if (m_st == 1) m_st = any_mw ? 2 : 0;
        else if (m_st == 2) m_st = s.mem_rdy ? 0 : 2;
        if (s.rst || s.flush) clear_hist();
        else begin
            h.v = s.wb_wen && (s.wb_wa != 0); h.a = s.wb_wa; h.d = s.wb_wd;
            hist.push_front(h);
            void'(hist.pop_back());
        end
    endtask

    // Monitor: pop one expectation per cycle and compare mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int p = 0; p < NRD; p++) begin
                    chk($sformatf("sel%0d", p),  64'(bus.fwd_sel[2*p +: 2]),        64'(e.sel[p]));
                    chk($sformatf("data%0d", p), 64'(bus.fwd_data[p*DATA_W +: DATA_W]), 64'(e.data[p]));
                end
                chk("stall",        64'(bus.stall),        64'(e.stall));
                chk("stall_cycles", 64'(bus.stall_cycles), 64'(e.cnt));
                chk("state",        64'(bus.hz_state),     64'(e.st));
            end
        end
    end

    initial begin
        stim_t s;
        drive(idle_s());
        rst = 1;
        repeat (2) @(posedge clk);
        m_cnt = 0; m_st = 0; clear_hist();

        // reset state
        apply(idle_s());

        // MEM and WB both write r5: MEM wins
        s = idle_s();
        s.mem_wen = 1; s.mem_wa = 5; s.mem_wd = 32'hAAAA0001;
        s.wb_wen = 1;  s.wb_wa = 5;  s.wb_wd = 32'hBBBB0002;
        s.used = 2'b01; s.rs[0] = 5;
        apply(s);

        // WB r7 then read through history until it ages out
        s = idle_s(); s.wb_wen = 1; s.wb_wa = 7; s.wb_wd = 32'h12345678;
        apply(s);
        s = idle_s(); s.used = 2'b10; s.rs[1] = 7;
        repeat (HD + 1) apply(s);

        // load-use on r3, then load in MEM with data ready
        s = idle_s(); s.ex_wen = 1; s.ex_ld = 1; s.ex_wa = 3; s.used = 2'b01; s.rs[0] = 3;
        apply(s);
        s = idle_s(); s.mem_wen = 1; s.mem_ld = 1; s.mem_rdy = 1; s.mem_wa = 3;
        s.mem_wd = 32'hC0DE0003; s.used = 2'b01; s.rs[0] = 3;
        apply(s);

        // MEM load r4 waits 3 cycles, then forwards
        s = idle_s(); s.mem_wen = 1; s.mem_ld = 1; s.mem_rdy = 0; s.mem_wa = 4;
        s.mem_wd = 32'h44444444; s.used = 2'b10; s.rs[1] = 4;
        repeat (3) apply(s);
        s.mem_rdy = 1;
        apply(s);

        // r0 everywhere never forwards or stalls
        s = idle_s(); s.ex_wen = 1; s.ex_ld = 1; s.mem_wen = 1; s.mem_ld = 1; s.mem_rdy = 0;
        s.mem_wd = 32'hDEAD; s.wb_wen = 1; s.wb_wd = 32'hBEEF; s.used = 2'b11;
        apply(s);
        apply(idle_s());

        // flush mid MEM_WAIT, history loaded beforehand
        s = idle_s(); s.wb_wen = 1; s.wb_wa = 9; s.wb_wd = 32'h99;
        apply(s);
        s = idle_s(); s.mem_wen = 1; s.mem_ld = 1; s.mem_rdy = 0; s.mem_wa = 6;
        s.used = 2'b11; s.rs[0] = 6; s.rs[1] = 9;
        apply(s); apply(s);
        s.flush = 1; apply(s);
        s = idle_s(); s.used = 2'b10; s.rs[1] = 9;
        apply(s);

        // reset mid MEM_WAIT
        s = idle_s(); s.mem_wen = 1; s.mem_ld = 1; s.mem_rdy = 0; s.mem_wa = 6;
        s.used = 2'b01; s.rs[0] = 6;
        apply(s); apply(s);
        s.rst = 1; apply(s);
        apply(idle_s());

        // counter saturation
        s = idle_s(); s.ex_wen = 1; s.ex_ld = 1; s.ex_wa = 2; s.used = 2'b01; s.rs[0] = 2;
        repeat (CMAX + 4) apply(s);
        s = idle_s(); s.rst = 1; apply(s);

        // random traffic
        for (int n = 0; n < 500; n++) begin
            s.rst     = ($urandom_range(0, 63) == 0);
            s.flush   = ($urandom_range(0, 31) == 0);
            s.rs[0]   = 5'($urandom_range(0, 7));
            s.rs[1]   = 5'($urandom_range(0, 7));
            s.used    = 2'($urandom_range(0, 3));
            s.ex_wen  = 1'($urandom_range(0, 1));
            s.ex_ld   = ($urandom_range(0, 3) == 0);
            s.ex_wa   = 5'($urandom_range(0, 7));
            s.mem_wen = 1'($urandom_range(0, 1));
            s.mem_ld  = 1'($urandom_range(0, 1));
            s.mem_rdy = ($urandom_range(0, 3) != 0);
            s.mem_wa  = 5'($urandom_range(0, 7));
            s.mem_wd  = $urandom;
            s.wb_wen  = 1'($urandom_range(0, 1));
            s.wb_wa   = 5'($urandom_range(0, 7));
            s.wb_wd   = $urandom;
            apply(s);
        end

        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
